// File: rtl/imul_req_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imul_req_pkg                                                               |
// | Shared types and widths for the multiplier request queue.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package imul_req_pkg;

  localparam int c_imul_req_nbits = 64;
  localparam int c_imul_op_nbits  = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } imul_req_msg_t;

endpackage : imul_req_pkg
`default_nettype wire

// File: rtl/imul_popcount.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imul_popcount                                                              |
// | Purely combinational count of set bits in an operand.                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module imul_popcount
  import imul_req_pkg::*;
#(
  parameter int p_nbits = c_imul_op_nbits
) (
  input  logic [p_nbits-1:0]         bits_i,
  output logic [$clog2(p_nbits+1)-1:0] count_o
);

  localparam int c_cnt_w = $clog2(p_nbits + 1);

  logic [c_cnt_w-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < p_nbits; i++) begin
      sum = sum + c_cnt_w'(bits_i[i]);
    end
  end

  assign count_o = sum;

endmodule : imul_popcount
`default_nettype wire

// File: rtl/imul_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imul_req_queue                                                             |
// | Circular request FIFO (no bypass, no pipe) feeding the iterative           |
// | multiplier. Optional IMUL_REQ_QUEUE_OPERAND_SWAP_EN presents the operand   |
// | with more set bits as 'a' on the deq side.                                 |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module imul_req_queue
  import imul_req_pkg::*;
#(
  parameter int p_num_entries = 2,
  parameter int p_nbits       = c_imul_op_nbits
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enq_val,
  output logic                               enq_rdy,
  input  logic [2*p_nbits-1:0]               enq_msg,
  output logic                               deq_val,
  input  logic                               deq_rdy,
  output logic [2*p_nbits-1:0]               deq_msg,
  output logic [$clog2(p_num_entries+1)-1:0] num_free
);

  localparam int c_cnt_w = $clog2(p_num_entries + 1);
  localparam int c_ptr_w = $clog2(p_num_entries);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(p_num_entries);
  localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(p_num_entries - 1);

  logic [2*p_nbits-1:0] mem_q [p_num_entries];
  logic [c_ptr_w-1:0]   enq_ptr_q, enq_ptr_d;
  logic [c_ptr_w-1:0]   deq_ptr_q, deq_ptr_d;
  logic [c_cnt_w-1:0]   count_q, count_d;
  logic                 enq_go, deq_go;
  logic [2*p_nbits-1:0] head_msg;

  // Handshake flags decode only the registered count, so full blocks enq even while draining.
  assign enq_rdy  = (count_q != c_depth);
  assign deq_val  = (count_q != '0);
  assign enq_go   = enq_val & enq_rdy;
  assign deq_go   = deq_val & deq_rdy;
  assign num_free = c_depth - count_q;

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (enq_go) begin
      enq_ptr_d = (enq_ptr_q == c_last) ? '0 : enq_ptr_q + c_ptr_w'(1);
    end
    if (deq_go) begin
      deq_ptr_d = (deq_ptr_q == c_last) ? '0 : deq_ptr_q + c_ptr_w'(1);
    end
    case ({enq_go, deq_go})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is intentionally left out of reset; entries are only meaningful under count.
  always_ff @(posedge clk) begin
    if (enq_go) begin
      mem_q[enq_ptr_q] <= enq_msg;
    end
  end

  assign head_msg = mem_q[deq_ptr_q];

`ifdef IMUL_REQ_QUEUE_OPERAND_SWAP_EN
  localparam int c_pc_w = $clog2(p_nbits + 1);

  logic [c_pc_w-1:0] pc_a, pc_b;

  imul_popcount #(.p_nbits(p_nbits)) u_pc_a (
    .bits_i  (head_msg[2*p_nbits-1:p_nbits]),
    .count_o (pc_a)
  );

  imul_popcount #(.p_nbits(p_nbits)) u_pc_b (
    .bits_i  (head_msg[p_nbits-1:0]),
    .count_o (pc_b)
  );

  // Ties keep the original order; storage never holds the swapped form.
  assign deq_msg = (pc_b > pc_a) ? {head_msg[p_nbits-1:0], head_msg[2*p_nbits-1:p_nbits]}
                                 : head_msg;
`else
  assign deq_msg = head_msg;
`endif

endmodule : imul_req_queue
`default_nettype wire

// File: tb/tb_imul_req_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imul_req_queue                                                          |
// | Self-checking bench: vector table, reset corner case, randomized model.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_imul_req_queue;
  import imul_req_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enq_val = 1'b0;
  logic        deq_rdy = 1'b0;
  logic [63:0] enq_msg = '0;

  logic        enq_rdy2, deq_val2, enq_rdy3, deq_val3;
  logic [63:0] deq_msg2, deq_msg3;
  logic [1:0]  nf2, nf3;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imul_req_queue #(.p_num_entries(2), .p_nbits(32)) dut2 (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(enq_rdy2), .enq_msg(enq_msg),
    .deq_val(deq_val2), .deq_rdy(deq_rdy), .deq_msg(deq_msg2), .num_free(nf2)
  );

  imul_req_queue #(.p_num_entries(3), .p_nbits(32)) dut3 (
    .clk(clk), .reset(reset), .enq_val(enq_val), .enq_rdy(enq_rdy3), .enq_msg(enq_msg),
    .deq_val(deq_val3), .deq_rdy(deq_rdy), .deq_msg(deq_msg3), .num_free(nf3)
  );

  typedef struct packed {
    logic        ev;
    logic [63:0] msg;
    logic        dr;
    logic        x_rdy;
    logic        x_val;
    logic [63:0] x_msg;
    logic [1:0]  x_free;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] a, input logic [31:0] b);
    imul_req_msg_t m;
    m.a = a;
    m.b = b;
    return m;
  endfunction

  // Expected deq presentation of a stored message.
  function automatic logic [63:0] pres(input logic [63:0] m);
`ifdef IMUL_REQ_QUEUE_OPERAND_SWAP_EN
    if ($countones(m[31:0]) > $countones(m[63:32])) return {m[31:0], m[63:32]};
`endif
    return m;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] q2 [$];
  logic [63:0] q3 [$];
  logic        hold;
  logic        e2, d2, e3, d3;

  initial begin
    // ev, msg, dr | rdy, val, msg, free
    tbl[0]  = '{1'b0, 64'h0,                        1'b0, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[1]  = '{1'b1, mk(32'd3, 32'd5),             1'b1, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[2]  = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b1, mk(32'd3, 32'd5),              2'd1};
    tbl[3]  = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[4]  = '{1'b1, mk(32'd1, 32'd2),             1'b0, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[5]  = '{1'b1, mk(32'd3, 32'd4),             1'b0, 1'b1, 1'b1, mk(32'd1, 32'd2),              2'd1};
    tbl[6]  = '{1'b1, mk(32'd5, 32'd6),             1'b0, 1'b0, 1'b1, mk(32'd1, 32'd2),              2'd0};
    tbl[7]  = '{1'b1, mk(32'd5, 32'd6),             1'b1, 1'b0, 1'b1, mk(32'd1, 32'd2),              2'd0};
    tbl[8]  = '{1'b1, mk(32'd5, 32'd6),             1'b1, 1'b1, 1'b1, mk(32'd3, 32'd4),              2'd1};
    tbl[9]  = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b1, mk(32'd5, 32'd6),              2'd1};
    tbl[10] = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[11] = '{1'b1, mk(32'h1, 32'hFFFF_FFFF),     1'b0, 1'b1, 1'b0, 64'h0,                         2'd2};
    tbl[12] = '{1'b1, mk(32'd3, 32'd5),             1'b0, 1'b1, 1'b1, pres(mk(32'h1, 32'hFFFF_FFFF)), 2'd1};
    tbl[13] = '{1'b0, 64'h0,                        1'b1, 1'b0, 1'b1, pres(mk(32'h1, 32'hFFFF_FFFF)), 2'd0};
    tbl[14] = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b1, mk(32'd3, 32'd5),              2'd1};
    tbl[15] = '{1'b0, 64'h0,                        1'b1, 1'b1, 1'b0, 64'h0,                         2'd2};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed vectors on the depth-2 queue
    for (int i = 0; i < 16; i++) begin
      enq_val = tbl[i].ev;
      enq_msg = tbl[i].msg;
      deq_rdy = tbl[i].dr;
      @(negedge clk);
      chk($sformatf("vec%0d enq_rdy", i), 64'(enq_rdy2), 64'(tbl[i].x_rdy));
      chk($sformatf("vec%0d deq_val", i), 64'(deq_val2), 64'(tbl[i].x_val));
      chk($sformatf("vec%0d num_free", i), 64'(nf2), 64'(tbl[i].x_free));
      if (tbl[i].x_val) chk($sformatf("vec%0d deq_msg", i), deq_msg2, tbl[i].x_msg);
      next_cycle();
    end

    // Reset mid-cycle with two entries held
    enq_val = 1'b1; deq_rdy = 1'b0; enq_msg = mk(32'd11, 32'd12);
    next_cycle();
    enq_msg = mk(32'd13, 32'd14);
    next_cycle();
    enq_val = 1'b0;
    @(negedge clk);
    chk("pre_reset num_free", 64'(nf2), 64'd0);
    chk("pre_reset deq_val", 64'(deq_val2), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_reset deq_val", 64'(deq_val2), 64'd0);
    chk("mid_reset num_free", 64'(nf2), 64'd2);
    chk("mid_reset enq_rdy", 64'(enq_rdy2), 64'd1);
    #1;
    reset = 1'b0;
    next_cycle();
    enq_val = 1'b1; enq_msg = mk(32'd7, 32'd8);
    @(negedge clk);
    chk("post_reset deq_val", 64'(deq_val2), 64'd0);
    next_cycle();
    enq_val = 1'b0;
    @(negedge clk);
    chk("post_reset head val", 64'(deq_val2), 64'd1);
    chk("post_reset head msg", deq_msg2, pres(mk(32'd7, 32'd8)));
    next_cycle();

    // Clean restart for the model-checked random phase
    reset = 1'b1;
    #2;
    reset = 1'b0;
    next_cycle();
    hold = 1'b0;

    for (int c = 0; c < 400; c++) begin
      if (c < 20) begin
        enq_val = 1'b1;
        deq_rdy = (c % 2 == 0);
      end else begin
        if (!hold) enq_val = ($urandom_range(0, 2) != 0);
        deq_rdy = ($urandom_range(0, 2) != 0);
      end
      if (!hold) begin
        case ($urandom_range(0, 3))
          0:       enq_msg = mk(32'h1, $urandom);
          1:       enq_msg = mk($urandom, 32'h1);
          default: enq_msg = {$urandom, $urandom};
        endcase
      end
      @(negedge clk);
      chk("rnd3 enq_rdy", 64'(enq_rdy3), 64'(q3.size() != 3));
      chk("rnd3 deq_val", 64'(deq_val3), 64'(q3.size() != 0));
      chk("rnd3 num_free", 64'(nf3), 64'(3 - q3.size()));
      if (q3.size() != 0) chk("rnd3 deq_msg", deq_msg3, pres(q3[0]));
      chk("rnd2 num_free", 64'(nf2), 64'(2 - q2.size()));
      if (q2.size() != 0) chk("rnd2 deq_msg", deq_msg2, pres(q2[0]));

      e3 = enq_val && (q3.size() < 3);
      d3 = deq_rdy && (q3.size() > 0);
      e2 = enq_val && (q2.size() < 2);
      d2 = deq_rdy && (q2.size() > 0);
      if (d3) void'(q3.pop_front());
      if (e3) q3.push_back(enq_msg);
      if (d2) void'(q2.pop_front());
      if (e2) q2.push_back(enq_msg);
      hold = enq_val && !e3;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule : tb_imul_req_queue
`default_nettype wire
